// File: rtl/imm_split_pkg.sv
// Shared definitions for the immediate encoder and the matching extender:
// extension opcodes, encoder FSM states and the classifier result record.
package imm_split_pkg;

    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_ZERO = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_SHL2 = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StHoldA
    } state_e;

    typedef struct packed {
        logic        pair;
        logic [1:0]  eop;
        logic [15:0] imm_hi;
        logic [15:0] imm_lo;
    } cls_t;

endpackage

// File: rtl/imm_split_if.sv
// Input constant stream plus encoded-beat output stream of imm_split.
interface imm_split_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_or;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_imm, out_eop, out_last, out_or
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_imm, out_eop, out_last, out_or
    );

endinterface

// File: rtl/imm_classify.sv
// Picks the cheapest extender encoding for a 32-bit constant; falls back to an
// upper/lower pair when no single beat can reproduce it.
module imm_classify
    import imm_split_pkg::*;
#(
    parameter bit ENABLE_SHL2 = 1'b1
) (
    input  logic [31:0] data_i,
    output cls_t        cls_o
);

    logic sext16;
    logic sext18;

    assign sext16 = (data_i[31:15] == '0) || (data_i[31:15] == '1);
    assign sext18 = (data_i[31:17] == '0) || (data_i[31:17] == '1);

    always_comb begin
        cls_o        = '0;
        cls_o.imm_lo = data_i[15:0];
        if (sext16) begin
            cls_o.eop    = EXT_SIGN;
            cls_o.imm_hi = data_i[15:0];
        end else if (data_i[31:16] == '0) begin
            cls_o.eop    = EXT_ZERO;
            cls_o.imm_hi = data_i[15:0];
        end else if (data_i[15:0] == '0) begin
            cls_o.eop    = EXT_LUI;
            cls_o.imm_hi = data_i[31:16];
        end else if (ENABLE_SHL2 && (data_i[1:0] == 2'b00) && sext18) begin
            cls_o.eop    = EXT_SHL2;
            cls_o.imm_hi = data_i[17:2];
        end else begin
            cls_o.pair   = 1'b1;
            cls_o.eop    = EXT_LUI;
            cls_o.imm_hi = data_i[31:16];
        end
    end

endmodule

// File: rtl/imm_split.sv
// Streaming immediate encoder: one or two registered (imm, eop) beats per
// accepted constant, with the lower half of a pair latched for beat B.
module imm_split
    import imm_split_pkg::*;
#(
    parameter bit ENABLE_SHL2 = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    imm_split_if.slave  bus_io
);

    state_e      state_q;
    logic        out_valid_q;
    logic [15:0] out_imm_q;
    logic [1:0]  out_eop_q;
    logic        out_last_q;
    logic        out_or_q;
    logic [15:0] lo_q;
    cls_t        cls;
    logic        in_ready;
    logic        in_acc;

    imm_classify #(
        .ENABLE_SHL2(ENABLE_SHL2)
    ) u_classify (
        .data_i(bus_io.in_data),
        .cls_o (cls)
    );

    // A held single beat can be replaced in the same edge it is consumed.
    assign in_ready = (state_q == StIdle) || ((state_q == StHold) && bus_io.out_ready);
    assign in_acc   = bus_io.in_valid && in_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_eop_q   <= EXT_SIGN;
            out_last_q  <= 1'b0;
            out_or_q    <= 1'b0;
            lo_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (in_acc) begin
                        state_q     <= cls.pair ? StHoldA : StHold;
                        out_valid_q <= 1'b1;
                        out_imm_q   <= cls.imm_hi;
                        out_eop_q   <= cls.eop;
                        out_last_q  <= !cls.pair;
                        out_or_q    <= 1'b0;
                        lo_q        <= cls.imm_lo;
                    end else if ((state_q == StHold) && bus_io.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                StHoldA: begin
                    if (bus_io.out_ready) begin
                        state_q    <= StHold;
                        out_imm_q  <= lo_q;
                        out_eop_q  <= EXT_ZERO;
                        out_last_q <= 1'b1;
                        out_or_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_imm   = out_imm_q;
    assign bus_io.out_eop   = out_eop_q;
    assign bus_io.out_last  = out_last_q;
    assign bus_io.out_or    = out_or_q;

endmodule

// File: tb/tb_imm_split.sv
// Bench for imm_split: directed scenarios plus a randomized stream reconstructed
// through an arithmetic model of the extender.
module tb_imm_split;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        last;
        logic        orb;
    } beat_t;

    localparam int NumRand = 10000;
    localparam int CycleLimit = 80000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    imm_split_if bus1 ();
    imm_split_if bus0 ();

    imm_split #(.ENABLE_SHL2(1'b1)) dut1 (.clk_i(clk), .reset_i(rst), .bus_io(bus1.slave));
    imm_split #(.ENABLE_SHL2(1'b0)) dut0 (.clk_i(clk), .reset_i(rst), .bus_io(bus0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Value the extender produces from one beat.
    function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
        int s;
        s = $signed(imm);
        case (eop)
            2'b00:   return s;
            2'b01:   return {16'h0000, imm};
            2'b10:   return {imm, 16'h0000};
            default: return s * 4;
        endcase
    endfunction

    // Expected beats for a constant, from the value ranges each encoding covers.
    task automatic encode(input logic [31:0] v, input bit shl2, inout beat_t q[$]);
        int s;
        s = $signed(v);
        if (s >= -32768 && s <= 32767) q.push_back('{v[15:0], 2'b00, 1'b1, 1'b0});
        else if (v < 32'h0001_0000) q.push_back('{v[15:0], 2'b01, 1'b1, 1'b0});
        else if (v % 32'h0001_0000 == 0) q.push_back('{v[31:16], 2'b10, 1'b1, 1'b0});
        else if (shl2 && (s % 4 == 0) && (s / 4 >= -32768) && (s / 4 <= 32767)) begin
            s = s / 4;
            q.push_back('{s[15:0], 2'b11, 1'b1, 1'b0});
        end else begin
            q.push_back('{v[31:16], 2'b10, 1'b0, 1'b0});
            q.push_back('{v[15:0], 2'b01, 1'b1, 1'b1});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 000000",
                     {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or});
        end
        checks++;
        if (bus1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", bus1.in_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus1.in_data = 32'hFFFF_8000; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or}
            !== {1'b1, 2'b00, 16'h8000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_sign: got %h required %h",
                     {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or},
                     {1'b1, 2'b00, 16'h8000, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: got out_valid=%b required 0", bus1.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] din [3];
        logic [20:0] exp [3];
        din = '{32'h0000_ABCD, 32'h1234_0000, 32'hFFFE_0004};
        // Last constant is SHL2 with imm = in_data[17:2] = 0x8001.
        exp = '{{1'b1, 2'b01, 16'hABCD, 1'b1, 1'b0},
                {1'b1, 2'b10, 16'h1234, 1'b1, 1'b0},
                {1'b1, 2'b11, 16'h8001, 1'b1, 1'b0}};
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or}
                    !== exp[i-1]) begin
                    failures++;
                    $display("FAIL b2b_beat%0d: got %h required %h", i - 1,
                             {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last,
                              bus1.out_or}, exp[i-1]);
                end
            end
            if (i < 3) begin
                bus1.in_data = din[i]; bus1.in_valid = 1'b1;
                #1;
                checks++;
                if (bus1.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready%0d: got %b required 1", i, bus1.in_ready);
                end
            end else begin
                bus1.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_pair();
        @(negedge clk);
        bus1.in_data = 32'h1234_5678; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or, bus1.in_ready}
            !== {1'b1, 2'b10, 16'h1234, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL pair_beat_a: got %h required %h",
                     {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or,
                      bus1.in_ready}, {1'b1, 2'b10, 16'h1234, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or}
            !== {1'b1, 2'b01, 16'h5678, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL pair_beat_b: got %h required %h",
                     {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or},
                     {1'b1, 2'b01, 16'h5678, 1'b1, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_drain: got out_valid=%b required 0", bus1.out_valid);
        end
    endtask

    task automatic test_shl2_option();
        logic [20:0] exp0 [4];
        exp0 = '{{1'b1, 2'b10, 16'h1234, 1'b0, 1'b0}, {1'b1, 2'b01, 16'h5678, 1'b1, 1'b1},
                 {1'b1, 2'b10, 16'h0001, 1'b0, 1'b0}, {1'b1, 2'b01, 16'h0004, 1'b1, 1'b1}};
        @(negedge clk);
        bus0.in_data = 32'h1234_5678; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus0.in_data = 32'h0001_0004;
            if (i == 2) bus0.in_valid = 1'b0;
            checks++;
            if ({bus0.out_valid, bus0.out_eop, bus0.out_imm, bus0.out_last, bus0.out_or}
                !== exp0[i]) begin
                failures++;
                $display("FAIL noshl2_beat%0d: got %h required %h", i,
                         {bus0.out_valid, bus0.out_eop, bus0.out_imm, bus0.out_last, bus0.out_or},
                         exp0[i]);
            end
        end
        @(negedge clk);
        bus1.in_data = 32'h0001_0004; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        checks++;
        if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or}
            !== {1'b1, 2'b11, 16'h4001, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL shl2_single: got %h required %h",
                     {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.out_last, bus1.out_or},
                     {1'b1, 2'b11, 16'h4001, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pair();
        @(negedge clk);
        bus1.in_data = 32'h1234_5678; bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus1.in_valid = 1'b0;
            #1;
            checks++;
            if ({bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.in_ready}
                !== {1'b1, 2'b10, 16'h1234, 1'b0}) begin
                failures++;
                $display("FAIL hold_a_cycle%0d: got %h required %h", k,
                         {bus1.out_valid, bus1.out_eop, bus1.out_imm, bus1.in_ready},
                         {1'b1, 2'b10, 16'h1234, 1'b0});
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus1.out_ready = 1'b1;
        #1;
        checks++;
        if ({bus1.out_valid, bus1.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midpair_reset: got valid,ready=%b required 01",
                     {bus1.out_valid, bus1.in_ready});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus1.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midpair_no_beat_b: got out_valid=%b required 0", bus1.out_valid);
            end
        end
    endtask

    task automatic test_random();
        beat_t       expq[$];
        logic [31:0] inq[$];
        beat_t       got;
        beat_t       held;
        bit          held_v;
        bit          pend;
        int          sent;
        int          cycles;
        int          r;
        logic [31:0] acc;
        logic [31:0] want;
        held_v = 1'b0; pend = 1'b0; sent = 0; cycles = 0; acc = '0;
        held = '0;
        bus1.in_valid = 1'b0;
        while ((sent < NumRand || expq.size() > 0) && cycles < CycleLimit) begin
            @(negedge clk);
            cycles++;
            got = '{bus1.out_imm, bus1.out_eop, bus1.out_last, bus1.out_or};
            if (held_v) begin
                checks++;
                if (bus1.out_valid !== 1'b1 || got !== held) begin
                    failures++;
                    $display("FAIL rand_stall_stable: got %b/%h required 1/%h",
                             bus1.out_valid, got, held);
                end
            end
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            if (!pend && sent < NumRand && $urandom_range(0, 9) < 7) begin
                r = $urandom();
                case ($urandom_range(0, 4))
                    0: bus1.in_data = {{16{r[15]}}, r[15:0]};
                    1: bus1.in_data = {16'h0000, r[15:0]};
                    2: bus1.in_data = {r[15:0], 16'h0000};
                    3: bus1.in_data = {{14{r[15]}}, r[15:0], 2'b00};
                    default: bus1.in_data = r;
                endcase
                bus1.in_valid = 1'b1;
                pend = 1'b1;
            end else if (!pend) begin
                bus1.in_valid = 1'b0;
            end
            #1;
            if (bus1.out_valid && bus1.out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_beat: got %h required no beat", got);
                end else begin
                    if (got !== expq[0]) begin
                        failures++;
                        $display("FAIL rand_beat: got %h required %h", got, expq[0]);
                    end
                    void'(expq.pop_front());
                    acc = got.orb ? (acc | ext(got.imm, got.eop)) : ext(got.imm, got.eop);
                    if (got.last && inq.size() > 0) begin
                        want = inq.pop_front();
                        checks++;
                        if (acc !== want) begin
                            failures++;
                            $display("FAIL rand_reconstruct: got %h required %h", acc, want);
                        end
                    end
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                encode(bus1.in_data, 1'b1, expq);
                inq.push_back(bus1.in_data);
                sent++;
                pend = 1'b0;
            end
            held_v = bus1.out_valid && !bus1.out_ready;
            held = got;
        end
        bus1.in_valid = 1'b0;
        checks++;
        if (sent != NumRand || expq.size() != 0) begin
            failures++;
            $display("FAIL rand_timeout: got sent=%0d pending=%0d required sent=%0d pending=0",
                     sent, expq.size(), NumRand);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_pair();
        test_shl2_option();
        test_reset_mid_pair();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
